// File: rtl/retire_trace_drain_pkg.sv
// Shared widths, trace record layout and drain FSM state encoding for the retire trace path.
package retire_trace_drain_pkg;

    localparam int TRACE_REC_WD  = 70;
    localparam int TRACE_WORD_WD = 32;
    localparam int META_PAD_WD   = TRACE_WORD_WD - 6;

    typedef struct packed {
        logic [31:0] pc;
        logic        wen;
        logic [4:0]  dest;
        logic [31:0] result;
    } trace_rec_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PC   = 2'd1,
        ST_RES  = 2'd2,
        ST_META = 2'd3
    } trace_state_e;

    function automatic logic [TRACE_WORD_WD-1:0] meta_word(input trace_rec_t rec);
        return {{META_PAD_WD{1'b0}}, rec.wen, rec.dest};
    endfunction

endpackage

// File: rtl/retire_trace_drain_if.sv
// Bundles the WB retirement push side and the serialized trace stream of retire_trace_drain.
interface retire_trace_drain_if
    import retire_trace_drain_pkg::*;
#(
    parameter int DEPTH = 8
) ();

    logic                       retired;
    logic [TRACE_REC_WD-1:0]    fifo_data;
    logic                       fifo_full;
    logic                       trace_valid;
    logic                       trace_ready;
    logic [TRACE_WORD_WD-1:0]   trace_data;
    logic                       trace_last;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic [31:0]                stall_cycles;

    modport master (
        output retired,
        output fifo_data,
        output trace_ready,
        input  fifo_full,
        input  trace_valid,
        input  trace_data,
        input  trace_last,
        input  fifo_count,
        input  stall_cycles
    );

    modport slave (
        input  retired,
        input  fifo_data,
        input  trace_ready,
        output fifo_full,
        output trace_valid,
        output trace_data,
        output trace_last,
        output fifo_count,
        output stall_cycles
    );

endinterface

// File: rtl/retire_trace_drain_trace_fifo.sv
// Synchronous record FIFO: registered storage, combinational head, wrap-bit pointers.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 70
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // DEPTH is a power of two, so the natural pointer overflow is the wrap to slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    assign o_head_data = r_mem[r_rd_ptr[AW-1:0]];
    assign o_empty     = (r_wr_ptr == r_rd_ptr);
    assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count     = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/retire_trace_drain.sv
// Buffers WB retirement records and drains each one as three trace words: PC, RES, META.
module retire_trace_drain
    import retire_trace_drain_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    retire_trace_drain_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic [CNT_W-1:0]           w_count;
    trace_rec_t                 w_head;
    trace_state_e               r_state;
    trace_state_e               w_state_next;
    logic [TRACE_WORD_WD-1:0]   w_trace_data;
    logic [31:0]                r_stall_cycles;

    // Full comes from registered pointers only, so a same-cycle pop never frees a slot for the push.
    assign w_push = bus.retired & ~w_full;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TRACE_REC_WD)
    ) u_trace_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (bus.fifo_data),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_trace_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_next = ST_PC;
                end
            end
            ST_PC: begin
                w_trace_data = w_head.pc;
                if (bus.trace_ready) begin
                    w_state_next = ST_RES;
                end
            end
            ST_RES: begin
                w_trace_data = w_head.result;
                if (bus.trace_ready) begin
                    w_state_next = ST_META;
                end
            end
            ST_META: begin
                w_trace_data = meta_word(w_head);
                // Head record retires here; chain straight into the next one when present.
                if (bus.trace_ready) begin
                    w_pop        = 1'b1;
                    w_state_next = (w_count > CNT_W'(1)) ? ST_PC : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (bus.retired && w_full && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.fifo_full    = w_full;
    assign bus.fifo_count   = w_count;
    assign bus.trace_valid  = (r_state != ST_IDLE);
    assign bus.trace_last   = (r_state == ST_META);
    assign bus.trace_data   = w_trace_data;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_retire_trace_drain.sv
// Directed bench for retire_trace_drain: latency, fill/stall, pop-vs-push, backpressure, wrap, reset.
module tb_retire_trace_drain;
    import retire_trace_drain_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    retire_trace_drain_if #(.DEPTH(8)) bus ();

    retire_trace_drain #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_of(input int i);
        return 32'h1C00_0000 + 32'(i) * 32'd4;
    endfunction

    function automatic logic [31:0] res_of(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'd7;
    endfunction

    function automatic logic wen_of(input int i);
        return i[0];
    endfunction

    function automatic logic [4:0] dest_of(input int i);
        return 5'(i + 1);
    endfunction

    function automatic logic [69:0] rec_of(input int i);
        return {pc_of(i), wen_of(i), dest_of(i), res_of(i)};
    endfunction

    task automatic exp_add(input int i);
        exp_q.push_back(pc_of(i));
        exp_q.push_back(res_of(i));
        exp_q.push_back({26'b0, wen_of(i), dest_of(i)});
    endtask

    // Consumes nbeats words; with toggle set, ready alternates 0/1 and stalled words are rechecked.
    task automatic drain(input int nbeats, input bit toggle, input int budget);
        int  idx = 0;
        int  cyc = 0;
        logic rdy;
        while (idx < nbeats && cyc < budget) begin
            rdy = toggle ? (cyc % 2 == 1) : 1'b1;
            bus.trace_ready = rdy;
            if (bus.trace_valid) begin
                check("beat_data", bus.trace_data, exp_q[idx]);
                check("beat_last", 32'(bus.trace_last), (idx % 3 == 2) ? 32'd1 : 32'd0);
                if (rdy) idx++;
            end
            tick();
            cyc++;
        end
        bus.trace_ready = 1'b0;
        check("drain_done", 32'(idx), 32'(nbeats));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   push_i;
        int   beat;
        int   cyc;
        logic pushed;

        bus.retired     = 1'b0;
        bus.fifo_data   = '0;
        bus.trace_ready = 1'b0;
        #2 rst = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(bus.trace_valid), 32'd0);
        check("rst_last",  32'(bus.trace_last), 32'd0);
        check("rst_data",  bus.trace_data, 32'd0);
        check("rst_full",  32'(bus.fifo_full), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_stall", bus.stall_cycles, 32'd0);
        rst = 1'b1;
        tick();

        // single record, two-cycle latency
        bus.trace_ready = 1'b1;
        bus.retired     = 1'b1;
        bus.fifo_data   = {32'h1C00_0000, 1'b1, 5'd5, 32'hDEAD_BEEF};
        tick();
        bus.retired   = 1'b0;
        bus.fifo_data = {70{1'b1}};
        check("t1_count_after_push", 32'(bus.fifo_count), 32'd1);
        check("t1_valid_cycle1",     32'(bus.trace_valid), 32'd0);
        tick();
        check("t1_valid_pc",  32'(bus.trace_valid), 32'd1);
        check("t1_data_pc",   bus.trace_data, 32'h1C00_0000);
        check("t1_last_pc",   32'(bus.trace_last), 32'd0);
        check("t1_ignore_data_count", 32'(bus.fifo_count), 32'd1);
        tick();
        check("t1_data_res",  bus.trace_data, 32'hDEAD_BEEF);
        check("t1_last_res",  32'(bus.trace_last), 32'd0);
        tick();
        check("t1_data_meta", bus.trace_data, 32'h0000_0025);
        check("t1_last_meta", 32'(bus.trace_last), 32'd1);
        tick();
        check("t1_idle_valid", 32'(bus.trace_valid), 32'd0);
        check("t1_idle_count", 32'(bus.fifo_count), 32'd0);
        bus.fifo_data = '0;

        // fill with consumer stalled
        bus.trace_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.retired   = 1'b1;
            bus.fifo_data = rec_of(i);
            tick();
        end
        check("fill_count", 32'(bus.fifo_count), 32'd8);
        check("fill_full",  32'(bus.fifo_full), 32'd1);
        check("fill_stall0", bus.stall_cycles, 32'd0);
        check("fill_head_pc", bus.trace_data, pc_of(0));
        bus.fifo_data = rec_of(8);
        tick();
        check("fill_stall1", bus.stall_cycles, 32'd1);
        check("fill_hold_count", 32'(bus.fifo_count), 32'd8);
        tick();
        check("fill_stall2", bus.stall_cycles, 32'd2);

        // META handshake coincides with a blocked push
        bus.trace_ready = 1'b1;
        tick();
        check("sim_res", bus.trace_data, res_of(0));
        tick();
        check("sim_meta_last",  32'(bus.trace_last), 32'd1);
        check("sim_meta_data",  bus.trace_data, 32'h0000_0001);
        check("sim_meta_count", 32'(bus.fifo_count), 32'd8);
        check("sim_meta_stall", bus.stall_cycles, 32'd4);
        tick();
        bus.trace_ready = 1'b0;
        check("sim_pop_count", 32'(bus.fifo_count), 32'd7);
        check("sim_pop_full",  32'(bus.fifo_full), 32'd0);
        check("sim_pop_stall", bus.stall_cycles, 32'd5);
        check("sim_next_pc",   bus.trace_data, pc_of(1));
        tick();
        bus.retired = 1'b0;
        check("sim_push_count", 32'(bus.fifo_count), 32'd8);
        check("sim_push_full",  32'(bus.fifo_full), 32'd1);
        check("sim_push_stall", bus.stall_cycles, 32'd5);

        // backpressure drain of records 1..8
        exp_q.delete();
        for (int i = 1; i <= 8; i++) exp_add(i);
        drain(24, 1'b1, 200);
        check("bp_empty_count", 32'(bus.fifo_count), 32'd0);
        check("bp_empty_valid", 32'(bus.trace_valid), 32'd0);

        // 20 records streamed continuously; pointers wrap
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_add(100 + i);
        push_i = 0;
        beat   = 0;
        cyc    = 0;
        bus.trace_ready = 1'b1;
        while (beat < 60 && cyc < 300) begin
            if (bus.trace_valid) begin
                check("wrap_data", bus.trace_data, exp_q[beat]);
                check("wrap_last", 32'(bus.trace_last), (beat % 3 == 2) ? 32'd1 : 32'd0);
                beat++;
            end
            if (push_i < 20) begin
                bus.retired   = 1'b1;
                bus.fifo_data = rec_of(100 + push_i);
                pushed        = ~bus.fifo_full;
            end else begin
                bus.retired = 1'b0;
                pushed      = 1'b0;
            end
            tick();
            if (pushed) push_i++;
            cyc++;
        end
        bus.retired     = 1'b0;
        bus.trace_ready = 1'b0;
        check("wrap_beats",  32'(beat), 32'd60);
        check("wrap_pushes", 32'(push_i), 32'd20);
        tick();
        check("wrap_empty", 32'(bus.fifo_count), 32'd0);

        // reset during a RES beat with 3 records buffered
        for (int i = 0; i < 3; i++) begin
            bus.retired   = 1'b1;
            bus.fifo_data = rec_of(200 + i);
            tick();
        end
        bus.retired = 1'b0;
        check("mr_pc", bus.trace_data, pc_of(200));
        bus.trace_ready = 1'b1;
        tick();
        bus.trace_ready = 1'b0;
        check("mr_res",   bus.trace_data, res_of(200));
        check("mr_count", 32'(bus.fifo_count), 32'd3);
        rst = 1'b0;
        #1;
        check("mr_rst_valid", 32'(bus.trace_valid), 32'd0);
        check("mr_rst_data",  bus.trace_data, 32'd0);
        check("mr_rst_last",  32'(bus.trace_last), 32'd0);
        check("mr_rst_count", 32'(bus.fifo_count), 32'd0);
        check("mr_rst_full",  32'(bus.fifo_full), 32'd0);
        check("mr_rst_stall", bus.stall_cycles, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("mr_post_valid", 32'(bus.trace_valid), 32'd0);
        bus.retired   = 1'b1;
        bus.fifo_data = rec_of(300);
        tick();
        bus.retired = 1'b0;
        check("mr_new_count", 32'(bus.fifo_count), 32'd1);
        check("mr_new_lat",   32'(bus.trace_valid), 32'd0);
        exp_q.delete();
        exp_add(300);
        drain(3, 1'b0, 20);
        check("mr_final_count", 32'(bus.fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
